// File: rtl/subleq_core_param_if.sv
// Single-port memory bus between the SUBLEQ core and program/data RAM.
// The master holds req/we/addr/wdata stable until ack completes the access.
interface subleq_core_param_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/subleq_core_param.sv
// Multi-cycle SUBLEQ core: mem[B] <= mem[B] - mem[A]; branch to C when the
// result is <= 0. An instruction whose taken target is all ones halts the core.
module subleq_core_param #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    subleq_core_param_if.master  mem,
    output logic                 busy,
    output logic                 halted,
    output logic [ADDR_W-1:0]    pc,
    output logic                 flag_z,
    output logic                 flag_n,
    output logic [CNT_W-1:0]     instr_count
);

    typedef enum logic [2:0] {
        IDLE, FETCH_A, FETCH_B, FETCH_C, READ_A, READ_B, WRITE_B, HALT
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [ADDR_W-1:0]         op_a;
    logic [ADDR_W-1:0]         op_b;
    logic [ADDR_W-1:0]         op_c;
    logic signed [DATA_W-1:0]  val_a;
    logic signed [DATA_W-1:0]  diff;
    logic                      access;
    logic                      acked;
    logic                      taken;

    function automatic logic signed [DATA_W-1:0] sub_wrap(
        input logic signed [DATA_W-1:0] minuend,
        input logic signed [DATA_W-1:0] subtrahend
    );
        return minuend - subtrahend;
    endfunction

    function automatic logic halt_target(input logic [ADDR_W-1:0] target);
        return &target;
    endfunction

    assign access = (state != IDLE) && (state != HALT);
    assign acked  = access && mem.mem_ack;
    assign busy   = access;
    assign halted = (state == HALT);
    // Flags saved at READ_B already encode "result <= 0" for the branch.
    assign taken  = flag_z | flag_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, HALT: if (start) state_next = FETCH_A;
            FETCH_A:    if (acked) state_next = FETCH_B;
            FETCH_B:    if (acked) state_next = FETCH_C;
            FETCH_C:    if (acked) state_next = READ_A;
            READ_A:     if (acked) state_next = READ_B;
            READ_B:     if (acked) state_next = WRITE_B;
            WRITE_B: begin
                if (acked) begin
                    if (taken && halt_target(op_c)) state_next = HALT;
                    else                            state_next = FETCH_A;
                end
            end
            default:    state_next = IDLE;
        endcase
    end

    // Bus outputs decode purely from registered state, so reset withdraws req at once.
    always_comb begin
        mem.mem_req   = access;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        case (state)
            FETCH_A: mem.mem_addr = pc;
            FETCH_B: mem.mem_addr = pc + ADDR_W'(1);
            FETCH_C: mem.mem_addr = pc + ADDR_W'(2);
            READ_A:  mem.mem_addr = op_a;
            READ_B:  mem.mem_addr = op_b;
            WRITE_B: begin
                mem.mem_addr  = op_b;
                mem.mem_we    = 1'b1;
                mem.mem_wdata = diff;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            op_a        <= '0;
            op_b        <= '0;
            op_c        <= '0;
            val_a       <= '0;
            diff        <= '0;
            flag_z      <= 1'b0;
            flag_n      <= 1'b0;
            instr_count <= '0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        pc          <= RESET_PC;
                        instr_count <= '0;
                    end
                end
                FETCH_A: if (acked) op_a <= mem.mem_rdata[ADDR_W-1:0];
                FETCH_B: if (acked) op_b <= mem.mem_rdata[ADDR_W-1:0];
                FETCH_C: if (acked) op_c <= mem.mem_rdata[ADDR_W-1:0];
                READ_A:  if (acked) val_a <= mem.mem_rdata;
                READ_B: begin
                    if (acked) begin
                        diff   <= sub_wrap(mem.mem_rdata, val_a);
                        flag_n <= sub_wrap(mem.mem_rdata, val_a) < 0;
                        flag_z <= sub_wrap(mem.mem_rdata, val_a) == '0;
                    end
                end
                WRITE_B: begin
                    if (acked) begin
                        instr_count <= instr_count + CNT_W'(1);
                        if (taken) begin
                            if (!halt_target(op_c)) pc <= op_c;
                        end else begin
                            pc <= pc + ADDR_W'(3);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_subleq_core_param.sv
// Directed bench for subleq_core_param: single-instruction vector table plus
// halt, restart, wait-state and mid-write reset sequences.
module tb_subleq_core_param;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic        halted;
    logic [7:0]  pc;
    logic        flag_z;
    logic        flag_n;
    logic [31:0] instr_count;

    logic [15:0] mem_arr [256];
    int          ack_delay = 0;
    int          wcnt = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          stab_viol = 0;

    subleq_core_param_if #(.DATA_W(16), .ADDR_W(8)) bus ();

    subleq_core_param #(.DATA_W(16), .ADDR_W(8), .RESET_PC(8'h00), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .mem(bus),
        .busy(busy), .halted(halted), .pc(pc),
        .flag_z(flag_z), .flag_n(flag_n), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata = mem_arr[bus.mem_addr];
    assign bus.mem_ack   = bus.mem_req && ((ack_delay == 0) || (wcnt == ack_delay));

    always @(posedge clk) begin
        if (bus.mem_req && bus.mem_ack && bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_wdata;
        if (!bus.mem_req || bus.mem_ack) wcnt <= 0;
        else                             wcnt <= wcnt + 1;
    end

    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic        prev_we = 1'b0;
    logic [7:0]  prev_addr = '0;
    logic [15:0] prev_wdata = '0;

    always @(negedge clk) begin
        if (bus.mem_req && prev_req && !prev_ack &&
            (bus.mem_addr != prev_addr || bus.mem_we != prev_we || bus.mem_wdata != prev_wdata))
            stab_viol <= stab_viol + 1;
        prev_req   <= bus.mem_req;
        prev_ack   <= bus.mem_ack;
        prev_we    <= bus.mem_we;
        prev_addr  <= bus.mem_addr;
        prev_wdata <= bus.mem_wdata;
    end

    typedef struct {
        logic [15:0] val_a;
        logic [15:0] val_b;
        bit          poke;
        logic [15:0] exp_b;
        logic [7:0]  exp_pc;
        logic        exp_z;
        logic        exp_n;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem_arr[i] = 16'h0000;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs until the first instruction retires; returns number of req cycles seen.
    task automatic run_one(input bit poke, input int budget, output int reqc);
        int cyc;
        cyc  = 0;
        reqc = 0;
        while (instr_count != 32'd1 && cyc < budget) begin
            if (bus.mem_req) reqc++;
            start = (poke && cyc == 2);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic wait_halt(input int budget);
        int cyc;
        cyc = 0;
        while (!halted && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int reqc;
        int viol0;
        int cyc;

        vecs[0] = '{16'd3,     16'd5,      1'b0, 16'd2,      8'd3,  1'b0, 1'b0};
        vecs[1] = '{16'd3,     16'd3,      1'b1, 16'd0,      8'd20, 1'b1, 1'b0};
        vecs[2] = '{16'd1,     16'h0000,   1'b0, 16'hFFFF,   8'd20, 1'b0, 1'b1};
        vecs[3] = '{16'd1,     16'h8000,   1'b1, 16'h7FFF,   8'd3,  1'b0, 1'b0};
        vecs[4] = '{16'd5,     16'd2,      1'b0, 16'hFFFD,   8'd20, 1'b0, 1'b1};
        vecs[5] = '{16'h8000,  16'h0000,   1'b0, 16'h8000,   8'd20, 1'b0, 1'b1};

        clear_mem();
        @(negedge clk);
        @(negedge clk);
        check("rst_req", bus.mem_req, 0);
        check("rst_busy", busy, 0);
        check("rst_pc", pc, 0);
        check("rst_count", instr_count, 0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            do_reset();
            clear_mem();
            mem_arr[0]  = 16'd10;
            mem_arr[1]  = 16'd11;
            mem_arr[2]  = 16'd20;
            mem_arr[10] = vecs[i].val_a;
            mem_arr[11] = vecs[i].val_b;
            pulse_start();
            run_one(vecs[i].poke, 40, reqc);
            check($sformatf("v%0d_count", i), instr_count, 1);
            check($sformatf("v%0d_reqcyc", i), reqc, 6);
            check($sformatf("v%0d_memb", i), mem_arr[11], vecs[i].exp_b);
            check($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
            check($sformatf("v%0d_z", i), flag_z, vecs[i].exp_z);
            check($sformatf("v%0d_n", i), flag_n, vecs[i].exp_n);
        end

        // Two-instruction program ending in a halt at address 3.
        do_reset();
        clear_mem();
        mem_arr[0] = 16'd10; mem_arr[1] = 16'd11; mem_arr[2] = 16'd3;
        mem_arr[3] = 16'd12; mem_arr[4] = 16'd12; mem_arr[5] = 16'h00FF;
        mem_arr[10] = 16'd1; mem_arr[11] = 16'd5; mem_arr[12] = 16'd7;
        pulse_start();
        wait_halt(100);
        check("halt_halted", halted, 1);
        check("halt_busy", busy, 0);
        check("halt_pc", pc, 3);
        check("halt_count", instr_count, 2);
        check("halt_mem12", mem_arr[12], 0);
        check("halt_mem11", mem_arr[11], 4);
        check("halt_z", flag_z, 1);
        reqc = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.mem_req) reqc++;
        end
        check("halt_noreq", reqc, 0);
        check("halt_pc_hold", pc, 3);
        pulse_start();
        check("restart_count", instr_count, 0);
        check("restart_pc", pc, 0);
        check("restart_halted", halted, 0);
        check("restart_addr", bus.mem_addr, 0);
        check("restart_req", bus.mem_req, 1);
        wait_halt(100);
        check("rehalt_count", instr_count, 2);
        check("rehalt_mem11", mem_arr[11], 3);

        // Three wait cycles on every access.
        ack_delay = 3;
        do_reset();
        clear_mem();
        mem_arr[0] = 16'd10; mem_arr[1] = 16'd11; mem_arr[2] = 16'd20;
        mem_arr[10] = 16'd3; mem_arr[11] = 16'd5;
        viol0 = stab_viol;
        pulse_start();
        run_one(1'b0, 100, reqc);
        check("ws_count", instr_count, 1);
        check("ws_reqcyc", reqc, 24);
        check("ws_memb", mem_arr[11], 2);
        check("ws_pc", pc, 3);
        check("ws_stable", stab_viol - viol0, 0);

        // Reset while WRITE_B is waiting for ack: the write must be abandoned.
        do_reset();
        pulse_start();
        cyc = 0;
        while (!bus.mem_we && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("ws_reached_write", bus.mem_we, 1);
        check("ws_write_data", bus.mem_wdata, 16'hFFFF);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_req", bus.mem_req, 0);
        check("mid_we", bus.mem_we, 0);
        check("mid_addr", bus.mem_addr, 0);
        check("mid_wdata", bus.mem_wdata, 0);
        check("mid_busy", busy, 0);
        check("mid_halted", halted, 0);
        check("mid_pc", pc, 0);
        check("mid_flags", {flag_z, flag_n}, 0);
        check("mid_count", instr_count, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("post_memb", mem_arr[11], 2);
        check("post_idle_req", bus.mem_req, 0);
        check("post_idle_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/subleq_core_param.md
# subleq_core_param

Parametrised multi-cycle SUBLEQ processor core, successor to the fixed-width single-memory URISC processor. It generalises data and address width and replaces the internal memory with an external single-port memory interface that tolerates wait states via a req/ack handshake. It adds start/halt run control, exposes the saved Z/N flags, and keeps a retired-instruction counter. It sits between the system top level and a shared program/data RAM.

## Interface
- DATA_W, 16: memory word width; operands and arithmetic are two's complement at this width; must be ≥ ADDR_W.
- ADDR_W, 8: memory address width; the PC is ADDR_W bits.
- RESET_PC, 0: PC value loaded on reset and on every start.
- CNT_W, 32: width of instr_count.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  begin execution from RESET_PC; sampled only in IDLE or HALT.
- mem_req  output  1  memory access request; held until acknowledged.
- mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  output  ADDR_W  access address; valid while mem_req=1.
- mem_wdata  output  DATA_W  write data; valid while mem_req=1 and mem_we=1.
- mem_rdata  input  DATA_W  read data; sampled on the edge where mem_req=1 and mem_ack=1.
- mem_ack  input  1  completes the current access; may be combinational, meaning it can be high in the same cycle that mem_req rises.
- busy  output  1  high in every state except IDLE and HALT.
- halted  output  1  high in HALT.
- pc  output  ADDR_W  address of the current (or halting) instruction.
- flag_z, flag_n  output  1  zero and negative flags of the last completed subtraction.
- instr_count  output  CNT_W  count of retired instructions; wraps modulo 2^CNT_W.

## Operation
- Instruction format: three consecutive words A, B, C at pc, pc+1, pc+2. Address arithmetic wraps modulo 2^ADDR_W.
- Semantics:
  - mem[B] ← mem[B] − mem[A], computed modulo 2^DATA_W.
  - If the result is ≤ 0 (signed), then pc ← C[ADDR_W-1:0]; otherwise pc ← pc+3.
- Operand words A, B and C use only their low ADDR_W bits as addresses.
- FSM states and the access each one issues:
  - IDLE: no access.
  - FETCH_A: read at pc.
  - FETCH_B: read at pc+1.
  - FETCH_C: read at pc+2.
  - READ_A: read at A.
  - READ_B: read at B.
  - WRITE_B: write the difference to B.
  - HALT: no access.
- State transitions:
  - IDLE or HALT with start=1 → FETCH_A. On this edge pc←RESET_PC, instr_count←0, halted←0.
  - Each access state advances to the next state only on an edge where mem_ack=1. Otherwise it holds, with mem_addr, mem_we and mem_wdata stable.
  - READ_B acknowledged: the difference is registered, and flag_z/flag_n are computed and saved on the same edge. flag_n = MSB of the difference; flag_z = (difference == 0).
  - WRITE_B acknowledged: instr_count is incremented, then the branch is resolved:
    - If the branch is taken and C[ADDR_W-1:0] is all ones, go to HALT. pc is not updated.
    - Otherwise update pc and go to FETCH_A.
- The halting instruction's write still completes and counts as retired.
- Overflow is not detected. The sign decision uses the wrapped result. Example: 0x8000−1 = 0x7FFF, which is positive.
- start while busy is ignored.
- mem_ack while mem_req=0 is ignored.

## Timing
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, halted=0, pc=RESET_PC, flag_z=0, flag_n=0, instr_count=0. State is IDLE.
- Reset mid-access: mem_req drops asynchronously and the in-flight write is abandoned. Memory must ignore a write whose req was withdrawn before ack.
- mem_req, mem_we, mem_addr and mem_wdata are registered outputs, or decoded only from the registered state.
- start accepted on edge 0 → mem_req=1 with mem_addr=RESET_PC in cycle 1.
- With mem_ack tied high, an instruction takes exactly 6 cycles. The next FETCH_A request appears the cycle after the WRITE_B ack.
- Each wait cycle (mem_ack=0) adds one cycle to its access.
- flag_z, flag_n, pc and instr_count change only on the edges defined in Operation.

## Test plan
- Reset check: assert reset mid-run → all outputs take their reset values combinationally, and state is IDLE after release.
- Positive result: DATA_W=16, ADDR_W=8, ack tied high. Memory: mem[0..2]={10,11,20}, mem[10]=3, mem[11]=5; pulse start → mem[11]=2, pc=3, flag_z=0, flag_n=0, instr_count=1, exactly 6 mem_req cycles.
- Zero result: same setup with mem[11]=3 → mem[11]=0, flag_z=1, pc=20.
- Negative and overflow: mem[10]=1, mem[11]=0x0000 → result 0xFFFF, flag_n=1, branch taken. Then mem[10]=1, mem[11]=0x8000 → result 0x7FFF, pc=3.
- Halt: C=0xFF, result ≤ 0 → write completes, halted=1, busy=0, pc still holds the instruction address, mem_req stays 0. A new start restarts at RESET_PC with instr_count cleared.
- Wait states: mem_ack delayed 3 cycles per access → 24 cycles per instruction with stable addr/we/wdata throughout. Assert reset during WRITE_B wait → mem_req falls immediately and mem[B] is unchanged.
